// File: rtl/vmul_pkg.sv
// Shared definitions for the signed/unsigned vector multiply sequencer.
// Holds the lane-precision and FSM state encodings, lane-count constants,
// and helpers that map a precision code to lane geometry.
package vmul_pkg;

  typedef enum logic [1:0] {
    PREC_8   = 2'b00,
    PREC_16  = 2'b01,
    PREC_32  = 2'b10,
    PREC_RSV = 2'b11
  } prec_e;

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    MUL,
    FIX,
    OUT
  } state_e;

  localparam int LANES_8   = 4;
  localparam int LANES_16  = 2;
  localparam int LANES_32  = 1;
  localparam int MAX_LANES = LANES_8;

  // Operand lane width in bits; the reserved code falls back to a single
  // 32-bit lane so downstream geometry is always defined.
  function automatic int lane_width(prec_e p);
    case (p)
      PREC_8:  return 8;
      PREC_16: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int lane_count(prec_e p);
    case (p)
      PREC_8:  return LANES_8;
      PREC_16: return LANES_16;
      default: return LANES_32;
    endcase
  endfunction

  // log2 of the number of 8-bit chunks per operand lane.
  function automatic int lane_shift(prec_e p);
    case (p)
      PREC_8:  return 0;
      PREC_16: return 1;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/vmul_sign_ctrl_if.sv
// Bus bundle for vmul_sign_ctrl: operand input stream, multiplier launch /
// completion bus, and result output stream.
//   slave  : the sequencer side (consumes operands, drives the multiplier,
//            produces results).
//   master : the environment side (operand source, multiplier core, result
//            sink).
interface vmul_sign_ctrl_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [1:0]  in_prec;
  logic        in_signed;

  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [1:0]  mul_prec;
  logic        mul_done;
  logic [63:0] mul_product;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_product;
  logic        out_err;

  modport slave (
    input  in_valid, in_a, in_b, in_prec, in_signed,
    input  mul_done, mul_product,
    input  out_ready,
    output in_ready,
    output mul_start, mul_a, mul_b, mul_prec,
    output out_valid, out_product, out_err
  );

  modport master (
    output in_valid, in_a, in_b, in_prec, in_signed,
    output mul_done, mul_product,
    output out_ready,
    input  in_ready,
    input  mul_start, mul_a, mul_b, mul_prec,
    input  out_valid, out_product, out_err
  );

endinterface

// File: rtl/vmul_lane_negate.sv
// Combinational per-lane two's-complement negation.
// Ports:
//   i_data [WIDTH]  packed lanes, LSB-first
//   i_prec          operand lane precision (product lanes are twice as wide
//                   when WIDTH=64)
//   i_neg  [4]      per-lane negate enable
//   o_data [WIDTH]  lanes with selected ones negated
// Negation inverts every bit above the lowest set bit of a lane; a chain of
// "some lower bit was set" is ORed through 8-bit chunks and restarted at each
// lane boundary, so no carry ever crosses lanes. Zero maps to zero and the
// most-negative value maps to itself.
module vmul_lane_negate
  import vmul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]     i_data,
  input  prec_e                i_prec,
  input  logic [MAX_LANES-1:0] i_neg,
  output logic [WIDTH-1:0]     o_data
);

  localparam int NCHUNK = WIDTH / 8;

  always_comb begin
    logic seen;
    int   shift;
    int   cpl_m1;
    logic [1:0] lane;
    // Product lanes span twice as many chunks as operand lanes.
    shift  = lane_shift(i_prec) + ((WIDTH == 64) ? 1 : 0);
    cpl_m1 = (1 << shift) - 1;
    seen   = 1'b0;
    lane   = 2'd0;
    o_data = i_data;
    for (int c = 0; c < NCHUNK; c++) begin
      if ((c & cpl_m1) == 0) seen = 1'b0;
      lane = 2'(c >> shift);
      for (int b = 0; b < 8; b++) begin
        if (i_neg[lane] && seen) o_data[c*8+b] = ~i_data[c*8+b];
        seen = seen | i_data[c*8+b];
      end
    end
  end

endmodule

// File: rtl/vmul_sign_ctrl.sv
// Sequencer wrapping an unsigned lane multiplier to provide signed and
// unsigned 4x8 / 2x16 / 1x32 vector multiplies.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  vmul_sign_ctrl_if.slave: operand stream (in_*), multiplier
//        launch/completion (mul_*), result stream (out_*)
// Flow: IDLE accepts an operand pair, ABS converts signed lanes to magnitudes
// and records which product lanes need negating, MUL launches the core and
// waits (bounded by TIMEOUT), FIX re-applies the sign per product lane, OUT
// holds the result until the sink accepts it. Reserved precision and timeout
// both complete through OUT with out_err set and a zero product.
module vmul_sign_ctrl
  import vmul_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int DATA_W  = 32
) (
  input logic clk,
  input logic rst,
  vmul_sign_ctrl_if.slave bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e               r_state;
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_b;
  prec_e                r_prec;
  logic                 r_signed;
  logic [MAX_LANES-1:0] r_neg;
  logic [7:0]           r_cnt;
  logic                 r_mul_start;
  logic [DATA_W-1:0]    r_mul_a;
  logic [DATA_W-1:0]    r_mul_b;
  logic [1:0]           r_mul_prec;
  logic [2*DATA_W-1:0]  r_prod;
  logic [2*DATA_W-1:0]  r_out_product;
  logic                 r_out_valid;
  logic                 r_out_err;

  logic [MAX_LANES-1:0] w_sign_a;
  logic [MAX_LANES-1:0] w_sign_b;
  logic [DATA_W-1:0]    w_mag_a;
  logic [DATA_W-1:0]    w_mag_b;
  logic [2*DATA_W-1:0]  w_fix;

  // Lane sign bits; unsigned transactions report every lane as positive.
  always_comb begin
    w_sign_a = '0;
    w_sign_b = '0;
    for (int k = 0; k < MAX_LANES; k++) begin
      if (r_signed && (k < lane_count(r_prec))) begin
        w_sign_a[k] = r_a[(k+1)*lane_width(r_prec)-1];
        w_sign_b[k] = r_b[(k+1)*lane_width(r_prec)-1];
      end
    end
  end

  vmul_lane_negate #(.WIDTH(DATA_W)) u_neg_a (
    .i_data (r_a),
    .i_prec (r_prec),
    .i_neg  (w_sign_a),
    .o_data (w_mag_a)
  );

  vmul_lane_negate #(.WIDTH(DATA_W)) u_neg_b (
    .i_data (r_b),
    .i_prec (r_prec),
    .i_neg  (w_sign_b),
    .o_data (w_mag_b)
  );

  vmul_lane_negate #(.WIDTH(2*DATA_W)) u_neg_p (
    .i_data (r_prod),
    .i_prec (r_prec),
    .i_neg  (r_neg),
    .o_data (w_fix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_prec        <= PREC_8;
      r_signed      <= 1'b0;
      r_neg         <= '0;
      r_cnt         <= '0;
      r_mul_start   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_mul_prec    <= '0;
      r_prod        <= '0;
      r_out_product <= '0;
      r_out_valid   <= 1'b0;
      r_out_err     <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        // IDLE -> ABS (or straight to OUT for the reserved precision)
        IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.in_a;
            r_b      <= bus.in_b;
            r_prec   <= prec_e'(bus.in_prec);
            r_signed <= bus.in_signed;
            if (prec_e'(bus.in_prec) == PREC_RSV) begin
              r_out_product <= '0;
              r_out_valid   <= 1'b1;
              r_out_err     <= 1'b1;
              r_state       <= OUT;
            end else begin
              r_state <= ABS;
            end
          end
        end
        // ABS -> MUL: magnitudes presented to the core with a launch pulse
        ABS: begin
          r_mul_a     <= w_mag_a;
          r_mul_b     <= w_mag_b;
          r_mul_prec  <= r_prec;
          r_neg       <= w_sign_a ^ w_sign_b;
          r_mul_start <= 1'b1;
          r_cnt       <= '0;
          r_state     <= MUL;
        end
        // MUL -> FIX on completion, or OUT with error when the wait expires.
        // A done pulse on the final counted cycle still wins.
        MUL: begin
          if (bus.mul_done) begin
            r_prod  <= bus.mul_product;
            r_state <= FIX;
          end else if (r_cnt == CNT_LAST) begin
            r_out_product <= '0;
            r_out_valid   <= 1'b1;
            r_out_err     <= 1'b1;
            r_state       <= OUT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // FIX -> OUT: per-lane sign restore of the unsigned product
        FIX: begin
          r_out_product <= w_fix;
          r_out_valid   <= 1'b1;
          r_out_err     <= 1'b0;
          r_state       <= OUT;
        end
        // OUT -> IDLE on the result handshake
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.mul_start   = r_mul_start;
  assign bus.mul_a       = r_mul_a;
  assign bus.mul_b       = r_mul_b;
  assign bus.mul_prec    = r_mul_prec;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_product = r_out_product;
  assign bus.out_err     = r_out_err;

endmodule

// File: tb/tb_vmul_sign_ctrl.sv
// Bench for vmul_sign_ctrl: directed cases plus randomized transactions,
// with an unsigned lane-multiplier model on the mul_* bus and a reference
// model computing lane products by integer arithmetic.
module tb_vmul_sign_ctrl;

  localparam int TO = 64;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  vmul_sign_ctrl_if bus ();

  vmul_sign_ctrl #(.TIMEOUT(TO), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lw_of(logic [1:0] prec);
    return (prec == 2'd0) ? 8 : (prec == 2'd1) ? 16 : 32;
  endfunction

  // Lane products as integers: each lane read as signed or unsigned,
  // multiplied, truncated to 2w bits.
  function automatic logic [63:0] ref_prod(logic [31:0] a, logic [31:0] b,
                                           logic [1:0] prec, logic sgn);
    int lw;
    longint va, vb;
    logic [63:0] p, m2, r;
    lw = lw_of(prec);
    m2 = (lw == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2*lw)) - 64'd1);
    r  = '0;
    for (int k = 0; k < 32/lw; k++) begin
      va = longint'((64'(a) >> (k*lw)) & ((64'd1 << lw) - 64'd1));
      vb = longint'((64'(b) >> (k*lw)) & ((64'd1 << lw) - 64'd1));
      if (sgn && va[lw-1]) va = va - (longint'(1) << lw);
      if (sgn && vb[lw-1]) vb = vb - (longint'(1) << lw);
      p = 64'(va * vb) & m2;
      r = r | (p << (k*2*lw));
    end
    return r;
  endfunction

  // Absolute value of each lane modulo 2^w.
  function automatic logic [31:0] ref_mag(logic [31:0] a, logic [1:0] prec, logic sgn);
    int lw;
    longint v, m;
    logic [63:0] r;
    lw = lw_of(prec);
    m  = (longint'(1) << lw) - 1;
    r  = '0;
    for (int k = 0; k < 32/lw; k++) begin
      v = (longint'(a) >> (k*lw)) & m;
      if (sgn && v[lw-1]) v = ((longint'(1) << lw) - v) & m;
      r = r | (64'(v) << (k*lw));
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h8080_8080;
      1: return 32'h8000_0000;
      2: return 32'h0000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_mul_start"}, 64'(bus.mul_start), 64'd0);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_out_err"},   64'(bus.out_err),   64'd0);
    chk({tag, "_mul_a"},     64'(bus.mul_a),     64'd0);
    chk({tag, "_mul_b"},     64'(bus.mul_b),     64'd0);
    chk({tag, "_mul_prec"},  64'(bus.mul_prec),  64'd0);
    chk({tag, "_out_prod"},  bus.out_product,    64'd0);
  endtask

  // One transaction from accept to result handshake. lat<0 means the
  // multiplier never answers. evc is the number of edges after the accept
  // edge at which out_valid is first seen.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] prec, input logic sgn,
                         input int lat, input int bp,
                         input logic [63:0] ep, input logic ee, input int evc);
    int cyc;
    int st;
    int n_start;
    logic [31:0] ca, cb;
    logic [1:0]  cp;
    logic [63:0] held;
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_prec   = prec;
    bus.in_signed = sgn;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0; st = -1; n_start = 0;
    ca = '0; cb = '0; cp = '0;
    while (!bus.out_valid && cyc < 200) begin
      if (bus.mul_start) begin
        n_start++;
        if (st < 0) begin
          st = cyc; ca = bus.mul_a; cb = bus.mul_b; cp = bus.mul_prec;
        end
      end
      bus.mul_done = (st >= 0 && lat >= 0 && cyc == st + lat);
      if (bus.mul_done) begin
        bus.mul_product = ref_prod(ca, cb, cp, 1'b0);
        chk("mul_a_hold", 64'(bus.mul_a), 64'(ca));
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.mul_done = 1'b0;
    if (cyc >= 200) begin
      chk("out_valid_wait", 64'd0, 64'd1);
      return;
    end
    chk("out_valid_edge", 64'(cyc), 64'(evc));
    chk("out_product", bus.out_product, ep);
    chk("out_err", 64'(bus.out_err), 64'(ee));
    chk("in_ready_out", 64'(bus.in_ready), 64'd0);
    if (prec == 2'b11) begin
      chk("rsv_no_start", 64'(n_start), 64'd0);
    end else begin
      chk("start_count", 64'(n_start), 64'd1);
      chk("start_edge", 64'(st), 64'd1);
      chk("mul_a", 64'(ca), 64'(ref_mag(a, prec, sgn)));
      chk("mul_b", 64'(cb), 64'(ref_mag(b, prec, sgn)));
      chk("mul_prec", 64'(cp), 64'(prec));
    end
    held = bus.out_product;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_hold", bus.out_product, held);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("valid_drop", 64'(bus.out_valid), 64'd0);
    chk("err_drop", 64'(bus.out_err), 64'd0);
    chk("ready_back", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [1:0]  prec;
    logic        sgn;
    int          lat;
    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_prec   = '0;
    bus.in_signed = 1'b0;
    bus.mul_done  = 1'b0;
    bus.mul_product = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // 8-bit signed, L=3: out_valid seen 6 edges after the accept edge
    run_txn(32'hFF80_02FD, 32'h0180_0302, 2'b00, 1'b1, 3, 0, 64'hFFFF_4000_0006_FFFA, 1'b0, 6);
    // 16-bit, signed and unsigned
    run_txn(32'h8000_FFFE, 32'h0002_0003, 2'b01, 1'b1, 2, 0, 64'hFFFF_0000_FFFF_FFFA, 1'b0, 5);
    run_txn(32'h8000_FFFE, 32'h0002_0003, 2'b01, 1'b0, 1, 0, 64'h0001_0000_0002_FFFA, 1'b0, 4);
    // 32-bit signed, magnitude of A is 1
    run_txn(32'hFFFF_FFFF, 32'h0000_0005, 2'b10, 1'b1, 4, 0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 7);
    // Most-negative lanes
    run_txn(32'h8080_8080, 32'h8080_8080, 2'b00, 1'b1, 2, 0, 64'h4000_4000_4000_4000, 1'b0, 5);
    run_txn(32'h8000_0000, 32'h0000_0001, 2'b10, 1'b1, 1, 0, 64'hFFFF_FFFF_8000_0000, 1'b0, 4);

    // Timeout, then a late done pulse while idle must be ignored
    run_txn(32'h1234_5678, 32'h0000_0003, 2'b10, 1'b1, -1, 0, 64'd0, 1'b1, 1 + TO);
    bus.mul_done    = 1'b1;
    bus.mul_product = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    bus.mul_done = 1'b0;
    chk("late_done_ready", 64'(bus.in_ready), 64'd1);
    chk("late_done_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    chk("late_done_start", 64'(bus.mul_start), 64'd0);

    // Backpressure for 5 cycles, then reserved precision
    run_txn(32'hFF80_02FD, 32'h0180_0302, 2'b00, 1'b1, 2, 5, 64'hFFFF_4000_0006_FFFA, 1'b0, 5);
    run_txn(32'hAAAA_5555, 32'h1111_2222, 2'b11, 1'b1, 2, 1, 64'd0, 1'b1, 0);

    // Reset while waiting in MUL aborts with no output
    bus.in_a = 32'h0000_0007; bus.in_b = 32'h0000_0009;
    bus.in_prec = 2'b10; bus.in_signed = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 64'(bus.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_reset");
    run_txn(32'hFFFE_0003, 32'h0005_FFF9, 2'b01, 1'b1, 3, 0, ref_prod(32'hFFFE_0003, 32'h0005_FFF9, 2'b01, 1'b1), 1'b0, 6);

    // Randomized transactions
    for (int i = 0; i < 40; i++) begin
      a    = pick_operand();
      b    = pick_operand();
      prec = 2'($urandom_range(0, 2));
      sgn  = 1'($urandom_range(0, 1));
      lat  = int'($urandom_range(1, 8));
      run_txn(a, b, prec, sgn, lat, int'($urandom_range(0, 3)),
              ref_prod(a, b, prec, sgn), 1'b0, 3 + lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
